sys_ctrl: RTL and testbench



---
 rtl/parameters_pkg.sv | 34 +++
 rtl/sys_ctrl_if.sv | 38 +++
 rtl/sys_ctrl_tx.sv | 96 +++++++++
 rtl/sys_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/parameters_pkg.sv
// Shared widths, command codes and state encodings for the system controller.
package parameters_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_FUN_WIDTH     = 4;
  localparam int DEF_ALU_OUT_WIDTH = 2 * DEF_DATA_WIDTH;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_WC  = 8'hCC;
  localparam logic [7:0] CMD_ALU_WNC = 8'hDD;

  localparam int ALU_OPA_ADDR = 0;
  localparam int ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV,
    OP_AND, OP_OR, OP_NAND, OP_NOR,
    OP_XOR, OP_XNOR, OP_CMP_EQ, OP_CMP_GT,
    OP_CMP_LT, OP_SHR, OP_SHL, OP_NOP
  } operation_e;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA,
    OPB, FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD
  } ctrl_state_e;

  // Push phases of the TX sequencer; *_PEND means that byte is still owed.
  typedef enum logic [1:0] {
    TXP_IDLE, TXP_LSB_PEND, TXP_MSB_PEND, TXP_BYTE_PEND
  } tx_phase_e;

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the controller and the UART RX, register file, ALU and TX FIFO.
interface sys_ctrl_if
  import parameters_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int FUN_WIDTH     = DEF_FUN_WIDTH,
  parameter int ALU_OUT_WIDTH = DEF_ALU_OUT_WIDTH
);

  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [DATA_WIDTH-1:0]    RdData;
  logic                     RdData_Valid;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     OUT_VALID;
  logic                     FIFO_FULL;
  logic                     WrEn;
  logic                     RdEn;
  logic [ADDR_WIDTH-1:0]    Address;
  logic [DATA_WIDTH-1:0]    WrData;
  logic                     ALU_EN;
  logic [FUN_WIDTH-1:0]     ALU_FUN;
  logic                     CLK_EN;
  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/sys_ctrl_tx.sv
// Holds a latched result or read byte and pushes it into the TX FIFO, LSB first,
// exactly once per byte, stalling while the FIFO reports full.
module sys_ctrl_tx
  import parameters_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    word,
  input  logic [2*DATA_WIDTH-1:0] value,
  input  logic                    fifo_full,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_vld,
  output logic                    lsb_sent,
  output logic                    done
);

  tx_phase_e                phase_q, phase_d;
  logic [2*DATA_WIDTH-1:0]  result_q, result_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     vld_q, vld_d;
  logic                     done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= TXP_IDLE;
      result_q <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      result_q <= result_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  // A start with room in the FIFO pushes its first byte on the same edge, so the
  // strobe lands one cycle after the result strobe.
  always_comb begin
    phase_d  = phase_q;
    result_d = result_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    case (phase_q)
      TXP_IDLE: begin
        if (start) begin
          result_d = value;
          if (fifo_full) begin
            phase_d = word ? TXP_LSB_PEND : TXP_BYTE_PEND;
          end else begin
            vld_d  = 1'b1;
            data_d = value[DATA_WIDTH-1:0];
            if (word) phase_d = TXP_MSB_PEND;
            else      done_d  = 1'b1;
          end
        end
      end
      TXP_LSB_PEND: begin
        if (!fifo_full) begin
          vld_d   = 1'b1;
          data_d  = result_q[DATA_WIDTH-1:0];
          phase_d = TXP_MSB_PEND;
        end
      end
      TXP_MSB_PEND: begin
        if (!fifo_full) begin
          vld_d   = 1'b1;
          data_d  = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          phase_d = TXP_IDLE;
          done_d  = 1'b1;
        end
      end
      TXP_BYTE_PEND: begin
        if (!fifo_full) begin
          vld_d   = 1'b1;
          data_d  = result_q[DATA_WIDTH-1:0];
          phase_d = TXP_IDLE;
          done_d  = 1'b1;
        end
      end
      default: phase_d = TXP_IDLE;
    endcase
  end

  assign tx_data  = data_q;
  assign tx_vld   = vld_q;
  assign lsb_sent = (phase_q == TXP_MSB_PEND);
  assign done     = done_q;

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes UART RX command frames into register-file writes/reads
// and ALU operations, gates the ALU clock and returns results through the TX FIFO.
module sys_ctrl
  import parameters_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int FUN_WIDTH     = DEF_FUN_WIDTH,
  parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic       CLK,
  input  logic       RST,
  sys_ctrl_if.master bus
);

  ctrl_state_e              state_q, state_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic                     alu_en_q, alu_en_d;
  logic [ADDR_WIDTH-1:0]    address_q, address_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;

  logic                     tx_start;
  logic                     tx_word;
  logic [ALU_OUT_WIDTH-1:0] tx_value;
  logic                     tx_lsb_sent;
  logic                     tx_done;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     tx_vld;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // RX bytes are only consumed in byte-collecting states; everywhere else they drop.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    tx_start  = 1'b0;
    tx_word   = 1'b0;
    tx_value  = '0;
    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          case (bus.RX_P_DATA)
            CMD_RF_WR:   state_d = WR_ADDR;
            CMD_RF_RD:   state_d = RD_ADDR;
            CMD_ALU_WC:  state_d = OPA;
            CMD_ALU_WNC: state_d = FUN;
            default:     state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.RX_P_DATA;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          tx_start = 1'b1;
          tx_value = ALU_OUT_WIDTH'(bus.RdData);
          state_d  = TX_RD;
        end
      end
      OPA: begin
        if (bus.RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(ALU_OPA_ADDR);
          wr_data_d = bus.RX_P_DATA;
          state_d   = OPB;
        end
      end
      OPB: begin
        if (bus.RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(ALU_OPB_ADDR);
          wr_data_d = bus.RX_P_DATA;
          state_d   = FUN;
        end
      end
      FUN: begin
        if (bus.RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = bus.RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.OUT_VALID) begin
          tx_start = 1'b1;
          tx_word  = 1'b1;
          tx_value = bus.ALU_OUT;
          state_d  = TX_LSB;
        end
      end
      TX_LSB: begin
        if (tx_lsb_sent) state_d = TX_MSB;
      end
      TX_MSB, TX_RD: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      address_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
    end
  end

  sys_ctrl_tx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (tx_start),
    .word      (tx_word),
    .value     (tx_value),
    .fifo_full (bus.FIFO_FULL),
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .lsb_sent  (tx_lsb_sent),
    .done      (tx_done)
  );

  // The ALU clock runs only while an operation is requested or in flight.
  assign bus.CLK_EN    = (state_q == FUN) || (state_q == ALU_WAIT);
  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.Address   = address_q;
  assign bus.WrData    = wr_data_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.TX_P_DATA = tx_data;
  assign bus.TX_D_VLD  = tx_vld;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: command frames, read-back, ALU results,
// TX backpressure, ignored bytes/strobes and mid-operation reset.
module tb_sys_ctrl;
  import parameters_pkg::*;

  logic clk;
  logic rst_n;

  int vector_count = 0;
  int miss_count   = 0;

  logic [11:0] wr_log[$];
  logic [7:0]  tx_log[$];
  int          rd_pulses;
  int          alu_pulses;

  sys_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .ALU_OUT_WIDTH(16)) bus ();

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .ALU_OUT_WIDTH(16)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are single-cycle, so log every one seen mid-cycle for later inspection.
  always @(negedge clk) begin
    if (bus.WrEn)     wr_log.push_back({bus.Address, bus.WrData});
    if (bus.TX_D_VLD) tx_log.push_back(bus.TX_P_DATA);
    if (bus.RdEn)     rd_pulses++;
    if (bus.ALU_EN)   alu_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge clk); #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clearLogs();
    wr_log.delete();
    tx_log.delete();
    rd_pulses  = 0;
    alu_pulses = 0;
  endtask

  function automatic logic [11:0] wrAt(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 12'hFFF;
  endfunction

  function automatic logic [7:0] txAt(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hXX;
  endfunction

  function automatic logic [31:0] allOutputs();
    return {bus.WrEn, bus.RdEn, bus.ALU_EN, bus.CLK_EN, bus.TX_D_VLD,
            bus.Address, bus.WrData, bus.ALU_FUN, bus.TX_P_DATA};
  endfunction

  initial begin
    rst_n            = 1'b0;
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.ALU_OUT      = '0;
    bus.OUT_VALID    = 1'b0;
    bus.FIFO_FULL    = 1'b0;
    clearLogs();

    // Reset state
    idleCycles(3);
    checkOutput("reset_outputs", allOutputs(), 32'h0);
    rst_n = 1'b1;
    idleCycles(2);

    // RF_W: AA,05,3C
    clearLogs();
    applyStimulus(8'hAA);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    checkOutput("rfw_wren_now", 32'(bus.WrEn), 32'h1);
    checkOutput("rfw_addr_now", 32'(bus.Address), 32'h5);
    idleCycles(3);
    checkOutput("rfw_wr_count", wr_log.size(), 1);
    checkOutput("rfw_wr0", 32'(wrAt(0)), 32'h53C);
    checkOutput("rfw_no_tx", tx_log.size(), 0);

    // RF_R: BB,05 then RdData 0x3C
    clearLogs();
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    checkOutput("rfr_rden_now", 32'(bus.RdEn), 32'h1);
    checkOutput("rfr_addr_now", 32'(bus.Address), 32'h5);
    idleCycles(1);
    bus.RdData       = 8'h3C;
    bus.RdData_Valid = 1'b1;
    @(posedge clk); #1;
    bus.RdData_Valid = 1'b0;
    checkOutput("rfr_txvld_next", 32'(bus.TX_D_VLD), 32'h1);
    checkOutput("rfr_txdata_next", 32'(bus.TX_P_DATA), 32'h3C);
    idleCycles(4);
    checkOutput("rfr_tx_count", tx_log.size(), 1);
    checkOutput("rfr_tx0", 32'(txAt(0)), 32'h3C);
    checkOutput("rfr_rd_pulses", rd_pulses, 1);

    // ALU_WC: CC,0A,03,00 then ALU_OUT 0x000D
    clearLogs();
    applyStimulus(8'hCC);
    checkOutput("wc_clken_opa", 32'(bus.CLK_EN), 32'h0);
    applyStimulus(8'h0A);
    applyStimulus(8'h03);
    checkOutput("wc_clken_fun", 32'(bus.CLK_EN), 32'h1);
    applyStimulus(OP_ADD);
    checkOutput("wc_aluen_now", 32'(bus.ALU_EN), 32'h1);
    checkOutput("wc_alufun_now", 32'(bus.ALU_FUN), 32'(OP_ADD));
    idleCycles(2);
    checkOutput("wc_clken_wait", 32'(bus.CLK_EN), 32'h1);
    applyStimulus(8'hAA);
    idleCycles(1);
    bus.ALU_OUT   = 16'h000D;
    bus.OUT_VALID = 1'b1;
    @(posedge clk); #1;
    bus.OUT_VALID = 1'b0;
    checkOutput("wc_clken_after", 32'(bus.CLK_EN), 32'h0);
    checkOutput("wc_lsb_vld", 32'(bus.TX_D_VLD), 32'h1);
    checkOutput("wc_lsb_data", 32'(bus.TX_P_DATA), 32'h0D);
    idleCycles(1);
    checkOutput("wc_msb_vld", 32'(bus.TX_D_VLD), 32'h1);
    checkOutput("wc_msb_data", 32'(bus.TX_P_DATA), 32'h00);
    idleCycles(4);
    checkOutput("wc_wr_count", wr_log.size(), 2);
    checkOutput("wc_wr0", 32'(wrAt(0)), 32'h00A);
    checkOutput("wc_wr1", 32'(wrAt(1)), 32'h103);
    checkOutput("wc_alu_pulses", alu_pulses, 1);
    checkOutput("wc_tx_count", tx_log.size(), 2);

    // ALU_WNC with FIFO_FULL held for 5 cycles
    clearLogs();
    bus.FIFO_FULL = 1'b1;
    applyStimulus(8'hDD);
    applyStimulus(8'h02);
    checkOutput("bp_alufun", 32'(bus.ALU_FUN), 32'h2);
    idleCycles(1);
    bus.ALU_OUT   = 16'h1E20;
    bus.OUT_VALID = 1'b1;
    @(posedge clk); #1;
    bus.OUT_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_quiet%0d", i), 32'(bus.TX_D_VLD), 32'h0);
      @(posedge clk); #1;
    end
    bus.FIFO_FULL = 1'b0;
    idleCycles(5);
    checkOutput("bp_tx_count", tx_log.size(), 2);
    checkOutput("bp_tx0", 32'(txAt(0)), 32'h20);
    checkOutput("bp_tx1", 32'(txAt(1)), 32'h1E);

    // Ignored byte and stray strobes in IDLE, then a normal write
    clearLogs();
    applyStimulus(8'h55);
    bus.RdData_Valid = 1'b1;
    bus.OUT_VALID    = 1'b1;
    @(posedge clk); #1;
    bus.RdData_Valid = 1'b0;
    bus.OUT_VALID    = 1'b0;
    idleCycles(3);
    checkOutput("ign_no_tx", tx_log.size(), 0);
    applyStimulus(8'hAA);
    applyStimulus(8'h17);
    applyStimulus(8'h11);
    idleCycles(2);
    checkOutput("ign_wr_count", wr_log.size(), 1);
    checkOutput("ign_wr0", 32'(wrAt(0)), 32'h711);

    // Reset during ALU_WAIT aborts, then AA,01,FF works
    clearLogs();
    applyStimulus(8'hDD);
    applyStimulus(8'h03);
    checkOutput("rst_clken_before", 32'(bus.CLK_EN), 32'h1);
    idleCycles(1);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_outputs", allOutputs(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ALU_OUT   = 16'hBEEF;
    bus.OUT_VALID = 1'b1;
    @(posedge clk); #1;
    bus.OUT_VALID = 1'b0;
    idleCycles(3);
    checkOutput("rst_no_tx", tx_log.size(), 0);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'hFF);
    checkOutput("rst_wren_now", 32'(bus.WrEn), 32'h1);
    checkOutput("rst_wr_entry", {20'h0, bus.Address, bus.WrData}, 32'h1FF);
    idleCycles(2);
    checkOutput("rst_wr_count", wr_log.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
